// File: rtl/xm_memory_interface.sv
// rtl/xm_memory_interface.sv - memory stage behind xm_datapath: word RAM with wait states and done/fault handshake
// Accepts one request at a time from IDLE; faults are decided at acceptance, so no RAM access follows them.
module xm_memory_interface #(
    parameter int WORD        = 16,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   req_i,
    input  logic                   wr_i,
    input  logic [WORD-(WORD/8):0] mar_i,
    input  logic [WORD-1:0]        data_i,
    input  logic [1:0]             datSel_i,
    input  logic                   badMem_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   fault_o,
    output logic [WORD-1:0]        data_o
);

    localparam int ADDR_W = WORD - (WORD / 8) + 1;
    localparam int RAM_AW = $clog2(MEM_WORDS);
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_FAULT} state_t;

    state_t state_q, state_d;
    logic [3:0]        cnt_q;
    logic [RAM_AW-1:0] addr_q;
    logic [WORD-1:0]   data_q;
    logic [1:0]        sel_q;
    logic              wr_q;
    logic              accept;
    logic              fault_req;
    logic              commit;
    logic [WORD-1:0]   ram [MEM_WORDS];

    assign accept    = (state_q == S_IDLE) && req_i;
    assign fault_req = badMem_i || (datSel_i == 2'b00) || ({1'b0, mar_i} >= MEM_LIMIT);
    // Last WAIT cycle: the edge that ends it both enters DONE and performs the access.
    assign commit    = (state_q == S_WAIT) && (cnt_q == 4'd0);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (req_i) state_d = fault_req ? S_FAULT : S_WAIT;
            S_WAIT:  if (cnt_q == 4'd0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_q == S_WAIT) || (state_q == S_DONE);
        done_o  = (state_q == S_DONE);
        fault_o = (state_q == S_FAULT);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q  <= 4'd0;
            addr_q <= '0;
            data_q <= '0;
            sel_q  <= 2'b00;
            wr_q   <= 1'b0;
        end else if (accept) begin
            cnt_q  <= 4'(WAIT_STATES);
            addr_q <= mar_i[RAM_AW-1:0];
            data_q <= data_i;
            sel_q  <= datSel_i;
            wr_q   <= wr_i;
        end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // RAM contents survive reset; an aborted write never reaches commit because reset forces IDLE.
    always_ff @(posedge clk_i) begin
        if (commit && wr_q) begin
            case (sel_q)
                2'b01:   ram[addr_q][7:0]  <= data_q[7:0];
                2'b10:   ram[addr_q][15:8] <= data_q[7:0];
                default: ram[addr_q]       <= data_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_o <= '0;
        end else if (commit && !wr_q) begin
            case (sel_q)
                2'b01:   data_o <= {{(WORD-8){1'b0}}, ram[addr_q][7:0]};
                2'b10:   data_o <= {{(WORD-8){1'b0}}, ram[addr_q][15:8]};
                default: data_o <= ram[addr_q];
            endcase
        end
    end

endmodule
